down_count_monitor: RTL and testbench
=====================================

# down_count_monitor

Downstream checker for the 4-bit synchronous down counter. It samples the counter's QD..QA outputs every cycle, locks onto a valid decrement sequence, and emits a one-cycle pulse on every underflow (0 -> 15). It also keeps a saturating epoch count of underflows and flags any illegal step. It sits between the counter and the system logic that consumes its terminal-count events.

## Interface
- EPOCH_W, 8, width of the epoch (underflow) counter; legal range 2..16
- SYNC_CNT, 2, consecutive correct decrements required to enter LOCK; legal range 1..7
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset rst, asynchronous, active-low; clock clk
- clr  input  1  synchronous clear; highest priority after rst
- en  input  1  cnt_in is valid and advanced this cycle; when 0 no check, state held
- cnt_in  input  4  counter value, bit3=QD .. bit0=QA
- wrap  output  1  registered one-cycle pulse per underflow seen in LOCK
- epoch  output  EPOCH_W  underflows counted since reset/clr; saturates at all-ones
- locked  output  1  high while state is LOCK
- err  output  1  sticky illegal-step flag
- state  output  2  IDLE=0, SYNC=1, LOCK=2, FAULT=3 (debug)

## Operation
- Internal registers: prev[3:0] (last valid sample), step_cnt[2:0], state, epoch, wrap, err.
- Good step: cnt_in == (prev - 1) mod 16. Underflow step: prev==0 && cnt_in==15 (also a good step).
- Reset (rst=0): state=IDLE, prev=0, step_cnt=0, wrap=0, epoch=0, locked=0, err=0.
- clr=1 at edge: same values as reset. Overrides en and all transitions.
- IDLE: en=1 -> prev<=cnt_in, step_cnt<=0, go SYNC. en=0 -> stay.
- SYNC: en=0 -> go IDLE. en=1 and good step -> step_cnt+1; if step_cnt+1==SYNC_CNT go LOCK, step_cnt<=0. en=1 and bad step -> step_cnt<=0, stay SYNC, no err. Underflows in SYNC are not counted and raise no wrap, even on the step that enters LOCK.
- LOCK: en=0 -> hold everything, prev kept; the next en=1 sample is checked against the held prev. en=1 and good step -> stay; on an underflow step wrap<=1 and epoch<=epoch+1 unless already all-ones. en=1 and bad step -> see Configuration.
- FAULT: ignores en and cnt_in; prev frozen; exits only via clr or rst.
- prev<=cnt_in on every edge with en=1 in IDLE, SYNC and LOCK.
- wrap<=0 on every edge where the underflow condition is not met in LOCK.

## Timing
- Combinational compare of cnt_in against registered prev; all outputs registered; latency 1 cycle.
- wrap is high in exactly the cycle following the edge that sampled 15 after 0; never two consecutive cycles, since the counter needs 16 steps between underflows.
- locked rises the cycle after the SYNC_CNT-th good step.
- With the counter free-running from reset (15,14,..), SYNC_CNT=2: IDLE at edge 1, SYNC at edges 2-3, LOCK from edge 3.
- Asynchronous rst mid-operation clears outputs immediately; the first edge after release behaves as IDLE.
- clr and an underflow at the same edge: clr wins, wrap=0, epoch=0.

## Configuration
- DCM_STEP_CHECK_EN defined: a bad step in LOCK -> FAULT, err<=1 (sticky), locked<=0, wrap<=0.
- DCM_STEP_CHECK_EN undefined: a bad step in LOCK -> SYNC with step_cnt<=0, prev<=cnt_in, err tied 0, FAULT unreachable. epoch is retained.

## Test plan
- Reset then free-running count 15..0 repeated 3 times, en=1, SYNC_CNT=2 -> locked by edge 3; wrap pulses exactly 2 times (the first 0->15 occurs after lock), epoch=2.
- EPOCH_W=2, 6 full wraps in LOCK -> epoch saturates at 3, and wrap still pulses 6 times.
- Locked at cnt_in=9, inject 6 (skip) with macro defined -> next cycle state=FAULT, err=1, locked=0; further valid counts leave err=1 until clr. Without the macro -> state=SYNC, err=0, relock after 2 good steps.
- Locked at prev=0, en=0 for 5 cycles while cnt_in changes, then en=1 with cnt_in=15 -> wrap pulse, no error.
- Underflow step coincident with clr=1 -> wrap=0, epoch=0, state=IDLE; rst pulsed low mid-LOCK asynchronously -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/down_count_monitor.sv
// Down-counter monitor: locks onto a 4-bit decrement sequence and pulses wrap on each 0->15 underflow seen in LOCK.
// Latency: 1 cycle. Every output comes from a register, except locked, which is decoded directly from the state register.
// Backpressure: none; en=0 freezes all state (wrap drops), FAULT holds until clr/rst.
//
// Ports: clk, rst (async active-low), clr (sync clear), en (sample valid),
//        cnt_in[3:0] (QD..QA) -> wrap, epoch[EPOCH_W-1:0], locked, err, state[1:0].
// Optional feature macro: DCM_STEP_CHECK_EN -- an illegal step in LOCK enters a sticky
// FAULT state and raises err. Without it, an illegal step drops back to SYNC and err is 0.
module down_count_monitor #(
    parameter int EPOCH_W  = 8,
    parameter int SYNC_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [3:0]         cnt_in,
    output logic               wrap,
    output logic [EPOCH_W-1:0] epoch,
    output logic               locked,
    output logic               err,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [3:0]         SYNC_TGT  = 4'(SYNC_CNT);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX = '1;

    state_t     st;
    logic [3:0] prev;
    logic [2:0] step_cnt;

    logic       good_step;
    logic       underflow;
    logic [3:0] step_next;

    // Modulo-16 wrap of prev - 1 makes 0 -> 15 a good step automatically.
    assign good_step = (cnt_in == (prev - 4'd1));
    assign underflow = (prev == 4'd0) && (cnt_in == 4'd15);
    // One bit wider so the compare against SYNC_CNT=7 cannot alias.
    assign step_next = {1'b0, step_cnt} + 4'd1;

    assign locked = (st == LOCK);
    assign state  = st;

`ifdef DCM_STEP_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            prev     <= 4'd0;
            step_cnt <= 3'd0;
            wrap     <= 1'b0;
            epoch    <= '0;
`ifdef DCM_STEP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else if (clr) begin
            st       <= IDLE;
            prev     <= 4'd0;
            step_cnt <= 3'd0;
            wrap     <= 1'b0;
            epoch    <= '0;
`ifdef DCM_STEP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // wrap is a single-cycle pulse; only an underflow in LOCK re-asserts it.
            wrap <= 1'b0;
            case (st)
                IDLE: begin
                    if (en) begin
                        prev     <= cnt_in;
                        step_cnt <= 3'd0;
                        st       <= SYNC;
                    end
                end
                SYNC: begin
                    if (!en) begin
                        st <= IDLE;
                    end else begin
                        prev <= cnt_in;
                        if (good_step) begin
                            if (step_next == SYNC_TGT) begin
                                st       <= LOCK;
                                step_cnt <= 3'd0;
                            end else begin
                                step_cnt <= step_next[2:0];
                            end
                        end else begin
                            step_cnt <= 3'd0;
                        end
                    end
                end
                LOCK: begin
                    // en=0 keeps prev so the next valid sample is checked against it.
                    if (en) begin
                        prev <= cnt_in;
                        if (good_step) begin
                            if (underflow) begin
                                wrap <= 1'b1;
                                if (epoch != EPOCH_MAX) begin
                                    epoch <= epoch + 1'b1;
                                end
                            end
                        end else begin
`ifdef DCM_STEP_CHECK_EN
                            st    <= FAULT;
                            err_q <= 1'b1;
`else
                            st       <= SYNC;
                            step_cnt <= 3'd0;
`endif
                        end
                    end
                end
                default: begin
                    // FAULT: frozen until clr or rst.
                    st <= st;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_count_monitor.sv
module tb_down_count_monitor;

    localparam int EPOCH_W  = 2;
    localparam int SYNC_CNT = 2;

    logic               clk;
    logic               rst;
    logic               clr;
    logic               en;
    logic [3:0]         cnt_in;
    logic               wrap;
    logic [EPOCH_W-1:0] epoch;
    logic               locked;
    logic               err;
    logic [1:0]         state;

    down_count_monitor #(.EPOCH_W(EPOCH_W), .SYNC_CNT(SYNC_CNT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .cnt_in(cnt_in),
        .wrap(wrap), .epoch(epoch), .locked(locked), .err(err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               wrap;
        logic [EPOCH_W-1:0] epoch;
        logic               locked;
        logic               err;
        logic [1:0]         state;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_seen = 0;
    logic last_wrap = 1'b0;

    // Reference model state
    logic [1:0]         m_state;
    logic [3:0]         m_prev;
    int                 m_step;
    logic               m_wrap;
    logic [EPOCH_W-1:0] m_epoch;
    logic               m_err;

    task automatic model_reset();
        m_state = 2'd0; m_prev = 4'd0; m_step = 0;
        m_wrap = 1'b0; m_epoch = '0; m_err = 1'b0;
    endtask

    task automatic model_update(input logic e, input logic [3:0] c, input logic cl);
        logic good;
        good = (c == 4'((m_prev + 4'd15) % 16));
        if (cl) begin
            model_reset();
        end else begin
            m_wrap = 1'b0;
            case (m_state)
                2'd0: if (e) begin m_prev = c; m_step = 0; m_state = 2'd1; end
                2'd1: begin
                    if (!e) m_state = 2'd0;
                    else begin
                        if (good) begin
                            m_step = m_step + 1;
                            if (m_step == SYNC_CNT) begin m_state = 2'd2; m_step = 0; end
                        end else m_step = 0;
                        m_prev = c;
                    end
                end
                2'd2: if (e) begin
                    if (good) begin
                        if (m_prev == 4'd0 && c == 4'd15) begin
                            m_wrap = 1'b1;
                            if (m_epoch != {EPOCH_W{1'b1}}) m_epoch = m_epoch + 1'b1;
                        end
                    end else begin
`ifdef DCM_STEP_CHECK_EN
                        m_state = 2'd3; m_err = 1'b1;
`else
                        m_state = 2'd1; m_step = 0;
`endif
                    end
                    m_prev = c;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of stimulus and push the model's prediction for that edge.
    task automatic step(input logic e, input logic [3:0] c, input logic cl);
        exp_t x;
        @(negedge clk);
        en = e; cnt_in = c; clr = cl;
        model_update(e, c, cl);
        x.wrap = m_wrap; x.epoch = m_epoch; x.locked = (m_state == 2'd2);
        x.err = m_err; x.state = m_state;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic run_seq(input int n, input logic [3:0] start);
        for (int i = 0; i < n; i++) step(1'b1, start - 4'(i), 1'b0);
    endtask

    // Scoreboard: pop the prediction for each edge and compare after outputs settle.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_x = sb_q.pop_front();
            n_checks++;
            if (wrap !== mon_x.wrap) begin
                n_fail++; $display("FAIL sb_wrap got=%b exp=%b t=%0t", wrap, mon_x.wrap, $time);
            end
            n_checks++;
            if (epoch !== mon_x.epoch) begin
                n_fail++; $display("FAIL sb_epoch got=%0d exp=%0d t=%0t", epoch, mon_x.epoch, $time);
            end
            n_checks++;
            if (locked !== mon_x.locked) begin
                n_fail++; $display("FAIL sb_locked got=%b exp=%b t=%0t", locked, mon_x.locked, $time);
            end
            n_checks++;
            if (err !== mon_x.err) begin
                n_fail++; $display("FAIL sb_err got=%b exp=%b t=%0t", err, mon_x.err, $time);
            end
            n_checks++;
            if (state !== mon_x.state) begin
                n_fail++; $display("FAIL sb_state got=%0d exp=%0d t=%0t", state, mon_x.state, $time);
            end
            n_checks++;
            if (wrap === 1'b1 && last_wrap === 1'b1) begin
                n_fail++; $display("FAIL wrap_twice got=11 exp=not-consecutive t=%0t", $time);
            end
            if (wrap === 1'b1) wrap_seen++;
            last_wrap = wrap;
        end
    end

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; en = 1'b0; cnt_in = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wrap, epoch, locked, err, state} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=0", {wrap, epoch, locked, err, state});
        end
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        wrap_seen = 0;
        run_seq(3, 4'd15);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL free_lock_edge3 got=%b exp=1", locked);
        end
        run_seq(45, 4'd12);
        n_checks++;
        if (wrap_seen != 2) begin
            n_fail++; $display("FAIL free_wrap_count got=%0d exp=2", wrap_seen);
        end
        n_checks++;
        if (epoch !== 2'd2) begin
            n_fail++; $display("FAIL free_epoch got=%0d exp=2", epoch);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 4'd0, 1'b1);
        wrap_seen = 0;
        run_seq(112, 4'd15);
        n_checks++;
        if (epoch !== 2'd3) begin
            n_fail++; $display("FAIL sat_epoch got=%0d exp=3", epoch);
        end
        n_checks++;
        if (wrap_seen != 6) begin
            n_fail++; $display("FAIL sat_wrap_count got=%0d exp=6", wrap_seen);
        end
    endtask

    task automatic test_en_hold();
        step(1'b0, 4'd0, 1'b1);
        run_seq(16, 4'd15);
        for (int i = 0; i < 5; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL hold_state got=%0d exp=2", state);
        end
        step(1'b1, 4'd15, 1'b0);
        n_checks++;
        if (wrap !== 1'b1 || err !== 1'b0 || epoch !== 2'd1) begin
            n_fail++; $display("FAIL hold_wrap got=w%b e%b ep%0d exp=w1 e0 ep1", wrap, err, epoch);
        end
    endtask

    task automatic test_bad_step();
        step(1'b0, 4'd0, 1'b1);
        run_seq(7, 4'd15);
        step(1'b1, 4'd6, 1'b0);
`ifdef DCM_STEP_CHECK_EN
        n_checks++;
        if (state !== 2'd3 || err !== 1'b1 || locked !== 1'b0) begin
            n_fail++; $display("FAIL bad_fault got=s%0d e%b l%b exp=s3 e1 l0", state, err, locked);
        end
        run_seq(3, 4'd5);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL bad_sticky got=%b exp=1", err);
        end
        step(1'b0, 4'd0, 1'b1);
        n_checks++;
        if (err !== 1'b0 || state !== 2'd0) begin
            n_fail++; $display("FAIL bad_clr got=e%b s%0d exp=e0 s0", err, state);
        end
`else
        n_checks++;
        if (state !== 2'd1 || err !== 1'b0) begin
            n_fail++; $display("FAIL bad_resync got=s%0d e%b exp=s1 e0", state, err);
        end
        run_seq(2, 4'd5);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL bad_relock got=%b exp=1", locked);
        end
`endif
    endtask

    task automatic test_clr_underflow();
        step(1'b0, 4'd0, 1'b1);
        run_seq(32, 4'd15);
        n_checks++;
        if (epoch !== 2'd1) begin
            n_fail++; $display("FAIL clr_pre_epoch got=%0d exp=1", epoch);
        end
        step(1'b1, 4'd15, 1'b1);
        n_checks++;
        if (wrap !== 1'b0 || epoch !== 2'd0 || state !== 2'd0) begin
            n_fail++; $display("FAIL clr_underflow got=w%b ep%0d s%0d exp=w0 ep0 s0", wrap, epoch, state);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 4'd0, 1'b1);
        run_seq(20, 4'd15);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({wrap, epoch, locked, err, state} !== '0) begin
            n_fail++; $display("FAIL async_rst got=%b exp=0", {wrap, epoch, locked, err, state});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4'd7, 1'b0);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL post_rst_idle got=%0d exp=1", state);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_saturation();
        test_en_hold();
        test_bad_step();
        test_clr_underflow();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
